// File: rtl/serial_adder4.sv
// -----------------------------------------------------------------------------
// serial_adder4
//
// Bit-serial adder that follows the operand preprocessing stage. It takes the
// conditioned operands AMod/BMod and a carry-in, and computes
// S = AMod + BMod + cin one bit per clock, LSB first. When it finishes it
// reports the sum, the carry-out, the signed overflow flag and the zero flag.
// A start/busy/done handshake controls each addition.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request; AMod/BMod/cin are sampled on an accepting edge
//   AMod   in   WIDTH  first operand
//   BMod   in   WIDTH  second operand
//   cin    in   1      carry into bit 0
//   busy   out  1      high while bits are being processed (RUN)
//   done   out  1      one-cycle pulse; results are valid from this cycle on
//   S      out  WIDTH  sum, held until the next result completes
//   Cout   out  1      carry out of bit WIDTH-1
//   Ovf    out  1      two's-complement overflow (carry into MSB ^ carry out)
//   Zero   out  1      high when S == 0
//
// Timing: if start is accepted at edge k, the RUN cycles are k+1..k+WIDTH and
// done is high in cycle k+WIDTH+1. A start seen during the DONE cycle begins
// the next addition immediately. A start seen during RUN is ignored.
// -----------------------------------------------------------------------------
module serial_adder4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] AMod,
    input  logic [WIDTH-1:0] BMod,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Working registers of the serial datapath
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] s_sh_reg, s_sh_next;
    logic             c_reg,    c_next;
    logic [CNT_W-1:0] cnt_reg,  cnt_next;

    // Committed result registers; they change only on entry to DONE
    logic [WIDTH-1:0] sum_reg,  sum_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg,  ovf_next;
    logic             zero_reg, zero_next;

    // One full-adder slice, always operating on the current LSBs
    logic sum_bit;
    logic carry_bit;

    assign sum_bit   = a_sh_reg[0] ^ b_sh_reg[0] ^ c_reg;
    assign carry_bit = (a_sh_reg[0] & b_sh_reg[0]) |
                       (a_sh_reg[0] & c_reg)       |
                       (b_sh_reg[0] & c_reg);

    // Shift networks. The operands move right, and the new sum bit enters
    // the sum register from the MSB side. After WIDTH steps the first sum bit
    // has reached bit 0.
    logic [WIDTH-1:0] a_shr;
    logic [WIDTH-1:0] b_shr;
    logic [WIDTH-1:0] s_ins;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_msb
                assign a_shr[gi] = 1'b0;
                assign b_shr[gi] = 1'b0;
                assign s_ins[gi] = sum_bit;
            end else begin : g_low
                assign a_shr[gi] = a_sh_reg[gi+1];
                assign b_shr[gi] = b_sh_reg[gi+1];
                assign s_ins[gi] = s_sh_reg[gi+1];
            end
        end
    endgenerate

    // Next-state and datapath control
    always_comb begin
        state_next = state_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        s_sh_next  = s_sh_reg;
        c_next     = c_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;
        zero_next  = zero_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                // DONE accepts start exactly like IDLE does, which allows
                // back-to-back additions with no idle cycle between them.
                if (start) begin
                    a_sh_next  = AMod;
                    b_sh_next  = BMod;
                    c_next     = cin;
                    s_sh_next  = '0;
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            ST_RUN: begin
                a_sh_next = a_shr;
                b_sh_next = b_shr;
                s_sh_next = s_ins;
                c_next    = carry_bit;
                cnt_next  = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    // On the MSB step, c_reg is the carry into the MSB and
                    // carry_bit is the carry out of the MSB.
                    sum_next   = s_ins;
                    cout_next  = carry_bit;
                    ovf_next   = c_reg ^ carry_bit;
                    zero_next  = (s_ins == '0);
                    state_next = ST_DONE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg <= '0;
            b_sh_reg <= '0;
            s_sh_reg <= '0;
            c_reg    <= 1'b0;
            cnt_reg  <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else begin
            a_sh_reg <= a_sh_next;
            b_sh_reg <= b_sh_next;
            s_sh_reg <= s_sh_next;
            c_reg    <= c_next;
            cnt_reg  <= cnt_next;
            sum_reg  <= sum_next;
            cout_reg <= cout_next;
            ovf_reg  <= ovf_next;
            zero_reg <= zero_next;
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign S    = sum_reg;
    assign Cout = cout_reg;
    assign Ovf  = ovf_reg;
    assign Zero = zero_reg;

endmodule

// File: tb/tb_serial_adder4.sv
// -----------------------------------------------------------------------------
// tb_serial_adder4
//
// Self-checking bench for serial_adder4. A reference model computes the sum,
// carry-out, signed overflow and zero flag from integer arithmetic. Inputs
// change on the falling edge, and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_adder4;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] AMod;
    logic [W-1:0] BMod;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
    logic         Ovf;
    logic         Zero;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    serial_adder4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .AMod  (AMod),
        .BMod  (BMod),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .Ovf   (Ovf),
        .Zero  (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain unsigned and signed integer arithmetic
    function automatic res_t model(input int a, input int b, input int ci);
        res_t r;
        int u;
        int sa;
        int sb;
        int ss;
        u  = a + b + ci;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        ss = sa + sb + ci;
        r.s    = W'(u % (1 << W));
        r.cout = (u >= (1 << W));
        r.ovf  = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
        r.zero = ((u % (1 << W)) == 0);
        return r;
    endfunction

    // Called at a negedge: present operands and assert start for the next edge
    task automatic launch(input int a, input int b, input int ci);
        start = 1'b1;
        AMod  = W'(a);
        BMod  = W'(b);
        cin   = ci[0];
    endtask

    // Walk the WIDTH RUN cycles. With hold set, start stays high and the
    // operands are scrambled, which must not affect the result.
    task automatic run_phase(input bit hold, input logic [W-1:0] prev_s);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check_eq($sformatf("busy_run%0d", i), busy, 1'b1);
            check_eq($sformatf("done_run%0d", i), done, 1'b0);
            check_eq($sformatf("S_hold_run%0d", i), S, prev_s);
            if (hold) begin
                start = 1'b1;
                AMod  = W'($urandom_range(0, (1 << W) - 1));
                BMod  = W'($urandom_range(0, (1 << W) - 1));
                cin   = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic done_phase(input string tag, input res_t e);
        @(negedge clk);
        check_eq({tag, "_done"}, done, 1'b1);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_S"},    S,    e.s);
        check_eq({tag, "_Cout"}, Cout, e.cout);
        check_eq({tag, "_Ovf"},  Ovf,  e.ovf);
        check_eq({tag, "_Zero"}, Zero, e.zero);
    endtask

    // One complete isolated addition, followed by an idle cycle
    task automatic single_add(input string tag, input int a, input int b, input int ci);
        res_t e;
        logic [W-1:0] prev;
        e    = model(a, b, ci);
        prev = S;
        @(negedge clk);
        launch(a, b, ci);
        run_phase(1'b0, prev);
        done_phase(tag, e);
        @(negedge clk);
        check_eq({tag, "_idle_done"}, done, 1'b0);
        check_eq({tag, "_idle_busy"}, busy, 1'b0);
        check_eq({tag, "_idle_S"},    S,    e.s);
        $display("add %s: %0h + %0h + %0d -> S=%0h Cout=%0b Ovf=%0b Zero=%0b",
                 tag, a, b, ci, S, Cout, Ovf, Zero);
    endtask

    initial begin
        res_t e1;
        res_t e2;
        int a;
        int b;
        int ci;

        n_checks = 0;
        n_fail   = 0;
        start    = 1'b0;
        AMod     = '0;
        BMod     = '0;
        cin      = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_S",    S,    '0);
        check_eq("rst_Cout", Cout, 1'b0);
        check_eq("rst_Ovf",  Ovf,  1'b0);
        check_eq("rst_Zero", Zero, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        single_add("t1_add",   4'b0011, 4'b0100, 0);
        single_add("t2_sub",   4'b0101, 4'b1100, 1);
        single_add("t3_ovfp",  4'b0111, 4'b0001, 0);
        single_add("t3_ovfn",  4'b1000, 4'b1111, 0);
        single_add("t4_zero",  4'b0101, 4'b1010, 1);
        single_add("max",      4'b1111, 4'b1111, 1);

        // Random operands
        for (int n = 0; n < 40; n++) begin
            a  = int'($urandom_range(0, (1 << W) - 1));
            b  = int'($urandom_range(0, (1 << W) - 1));
            ci = int'($urandom_range(0, 1));
            single_add($sformatf("rnd%0d", n), a, b, ci);
        end

        // Handshake: start held through RUN, then a back-to-back start in DONE
        e1 = model(4'b0110, 4'b0011, 1);
        e2 = model(4'b1001, 4'b1001, 0);
        @(negedge clk);
        launch(4'b0110, 4'b0011, 1);
        run_phase(1'b1, S);
        done_phase("hs_first", e1);
        launch(4'b1001, 4'b1001, 0);
        run_phase(1'b0, e1.s);
        done_phase("hs_second", e2);
        $display("handshake: first S=%0h, second S=%0h", e1.s, S);
        start = 1'b0;
        @(negedge clk);
        check_eq("hs_idle_done", done, 1'b0);

        // Asynchronous reset during RUN cycle 2 aborts the addition
        @(negedge clk);
        launch(4'b0111, 4'b0110, 0);
        @(posedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_done", done, 1'b0);
        check_eq("arst_S",    S,    '0);
        check_eq("arst_Cout", Cout, 1'b0);
        check_eq("arst_Ovf",  Ovf,  1'b0);
        check_eq("arst_Zero", Zero, 1'b0);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check_eq($sformatf("arst_nodone%0d", i), done, 1'b0);
            if (i == 1) rst_n = 1'b1;
        end
        $display("async reset mid-run: outputs cleared, no done pulse");
        single_add("post_rst", 4'b0001, 4'b0001, 0);
        check_eq("post_rst_S_val", S, 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
